// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : UART state encoding and baud arithmetic. The transmitter
//               imports this package too, so both sides derive identical
//               bit timing.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } uart_state_e;

    // Whole clocks per bit period (integer division).
    function automatic int clks_per_bit(input int clk_rate, input int baud_rate);
        return clk_rate / baud_rate;
    endfunction

    // Counter value at which the start bit is checked at its midpoint.
    function automatic int half_bit(input int cpb);
        return (cpb / 2) - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sync
// Description : Two-flop synchroniser for an asynchronous pin. Both flops
//               reset to 1, which is the idle level of a UART line.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    // Shift the pin through two flops to settle metastability.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 8N1 UART receiver, LSB first, mid-bit sampling, valid/ready
//               byte output with framing-error and overrun pulses.
//               Define UART_RX_PARITY_EN for 8E1 framing with parity_err.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_RATE  = 12000000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_RATE, BAUD_RATE);
    localparam int HALF_BIT     = half_bit(CLKS_PER_BIT);
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_WRAP = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT);
    localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

    logic rxs;

    uart_rx_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (rx),
        .q_o   (rxs)
    );

    uart_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             ferr_q, ferr_d;
    logic             ovr_q, ovr_d;
    logic             deliver;
    logic             par_ok;

`ifdef UART_RX_PARITY_EN
    logic par_q, par_d;
    logic perr_q, perr_d;

    // Even parity: data bits plus parity bit must XOR to zero.
    assign par_ok = ~(^{shift_q, par_q});
`else
    assign par_ok = 1'b1;
`endif

    // Next-state, sampling and error-pulse logic for the receive FSM.
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        ferr_d  = 1'b0;
        deliver = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!rxs) state_d = START;
            end
            START: begin
                // A start bit that is high again at its midpoint was a glitch.
                if (cnt_q == CNT_HALF) begin
                    state_d = rxs ? IDLE : DATA;
                    bit_d   = 3'd0;
                end
            end
            DATA: begin
                if (cnt_q == CNT_WRAP) begin
                    shift_d = {rxs, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == CNT_WRAP) begin
                    par_d   = rxs;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt_q == CNT_WRAP) begin
`ifdef UART_RX_PARITY_EN
                    perr_d = ~par_ok;
`endif
                    if (rxs) begin
                        deliver = par_ok;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end
                end
            end
            BREAK: begin
                // Hold here until the line returns high so a break flags once.
                if (rxs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        // Counter restarts on every state change, otherwise free-runs and wraps.
        if (state_d != state_q)    cnt_d = '0;
        else if (cnt_q == CNT_WRAP) cnt_d = '0;
        else                        cnt_d = cnt_q + 1'b1;
    end

    // Output handshake: load a finished byte if the slot is free, else flag overrun.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = 1'b0;
        if (deliver) begin
            if (!valid_q || rx_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity bit capture and parity-error pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            par_q  <= 1'b0;
            perr_q <= 1'b0;
        end else begin
            par_q  <= par_d;
            perr_q <= perr_d;
        end
    end

    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign rx_busy   = busy_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Directed self-checking bench for uart_rx.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int BIT_CLKS = 104;
    localparam int NOM_LAT  = 992 + (PAR_EN ? 104 : 0);

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    uart_rx dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .rx_busy    (rx_busy),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observation of pulses and byte deliveries on the falling edge.
    int         frame_cnt = 0;
    int         ovr_cnt = 0;
    int         par_cnt = 0;
    int         valid_cycles = 0;
    int         got_cyc = 0;
    logic [7:0] got[$];
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;

    always @(negedge clk) begin
        if (frame_err)  frame_cnt++;
        if (overrun)    ovr_cnt++;
        if (parity_err) par_cnt++;
        if (rx_valid)   valid_cycles++;
        if (rx_valid && (!prev_valid || prev_ready)) begin
            got.push_back(rx_data);
            got_cyc = cyc;
        end
        prev_valid = rx_valid;
        prev_ready = rx_ready;
    end

    int n_checks = 0;
    int n_fail   = 0;
    int t_start  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        tick(BIT_CLKS);
    endtask

    // Full frame; leaves rx at the stop-bit level when it returns.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit,
                             input logic bad_par, input logic ready_at_stop);
        t_start = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        if (PAR_EN) drive_bit((^b) ^ bad_par);
        rx = stop_bit;
        if (ready_at_stop) begin
            tick(50);
            rx_ready = 1'b1;
            tick(BIT_CLKS - 50);
        end else begin
            tick(BIT_CLKS);
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        tick(n);
    endtask

    int n0;
    int lat;

    initial begin
        reset    = 1'b1;
        rx       = 1'b1;
        rx_ready = 1'b0;
        tick(3);
        check("reset_rx_data",  32'(rx_data),  32'h0);
        check("reset_rx_valid", 32'(rx_valid), 32'h0);
        check("reset_rx_busy",  32'(rx_busy),  32'h0);
        check("reset_pulses",   32'({frame_err, overrun, parity_err}), 32'h0);
        reset = 1'b0;
        tick(10);

        // Single byte with latency measurement.
        rx_ready = 1'b1;
        send_byte(8'h43, 1'b1, 1'b0, 1'b0);
        idle(20);
        lat = got_cyc - t_start;
        check("single_count", 32'(got.size()), 32'd1);
        check("single_data", (got.size() > 0) ? 32'(got[0]) : 32'hFFFF, 32'h43);
        check("single_latency_window", 32'((lat >= NOM_LAT - 4) && (lat <= NOM_LAT + 4)), 32'd1);
        check("single_valid_one_cycle", 32'(valid_cycles), 32'd1);
        check("single_rx_data_hold", 32'(rx_data), 32'h43);

        // Back-to-back frames with no idle gap.
        n0 = got.size();
        send_byte(8'h55, 1'b1, 1'b0, 1'b0);
        send_byte(8'hAA, 1'b1, 1'b0, 1'b0);
        send_byte(8'h00, 1'b1, 1'b0, 1'b0);
        send_byte(8'hFF, 1'b1, 1'b0, 1'b0);
        idle(20);
        check("b2b_count", 32'(got.size() - n0), 32'd4);
        check("b2b_order", (got.size() == n0 + 4) ?
              {got[n0], got[n0+1], got[n0+2], got[n0+3]} : 32'hDEADBEEF, 32'h55AA00FF);
        check("b2b_no_errors", 32'(frame_cnt + ovr_cnt + par_cnt), 32'd0);

        // Glitch rejection.
        n0 = got.size();
        rx = 1'b0;
        tick(10);
        check("glitch_busy_set", 32'(rx_busy), 32'd1);
        tick(20);
        rx = 1'b1;
        tick(30);
        check("glitch_busy_clear_by_60", 32'(rx_busy), 32'd0);
        tick(200);
        check("glitch_no_byte", 32'(got.size() - n0), 32'd0);
        check("glitch_no_frame_err", 32'(frame_cnt), 32'd0);

        // Framing error followed by a long break.
        n0 = got.size();
        send_byte(8'h12, 1'b0, 1'b0, 1'b0);
        rx = 1'b0;
        tick(3000);
        idle(200);
        check("break_one_frame_err", 32'(frame_cnt), 32'd1);
        check("break_no_byte", 32'(got.size() - n0), 32'd0);
        check("break_busy_clear", 32'(rx_busy), 32'd0);
        send_byte(8'h34, 1'b1, 1'b0, 1'b0);
        idle(20);
        check("after_break_data", (got.size() == n0 + 1) ? 32'(got[n0]) : 32'hFFFF, 32'h34);

        // Overrun with the consumer stalled.
        rx_ready = 1'b0;
        n0 = got.size();
        send_byte(8'h11, 1'b1, 1'b0, 1'b0);
        send_byte(8'h22, 1'b1, 1'b0, 1'b0);
        idle(20);
        check("ovr_data_kept", 32'(rx_data), 32'h11);
        check("ovr_valid_held", 32'(rx_valid), 32'd1);
        check("ovr_one_pulse", 32'(ovr_cnt), 32'd1);
        check("ovr_one_delivery", 32'(got.size() - n0), 32'd1);
        send_byte(8'h33, 1'b1, 1'b0, 1'b1);
        idle(20);
        check("ovr_third_data", 32'(rx_data), 32'h33);
        check("ovr_third_no_overrun", 32'(ovr_cnt), 32'd1);
        check("ovr_third_last", 32'(got[got.size()-1]), 32'h33);

        // Reset during bit 4 of 0x5A.
        rx_ready = 1'b1;
        rx = 1'b0;
        tick(BIT_CLKS);
        for (int i = 0; i < 4; i++) drive_bit(1'(8'h5A >> i));
        rx = 1'b1;
        tick(50);
        check("midframe_busy", 32'(rx_busy), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midframe_reset_outputs", {rx_data, 5'd0, rx_valid, rx_busy, frame_err}, 32'h33000000 & 32'h0);
        tick(3);
        reset = 1'b0;
        idle(20);
        n0 = got.size();
        send_byte(8'hC3, 1'b1, 1'b0, 1'b0);
        idle(20);
        check("after_reset_data", (got.size() == n0 + 1) ? 32'(got[n0]) : 32'hFFFF, 32'hC3);

`ifdef UART_RX_PARITY_EN
        n0 = got.size();
        send_byte(8'h01, 1'b1, 1'b1, 1'b0);
        idle(20);
        check("parity_err_pulse", 32'(par_cnt), 32'd1);
        check("parity_no_byte", 32'(got.size() - n0), 32'd0);
`else
        check("parity_err_never", 32'(par_cnt), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver, LSB first; receive-side counterpart to the team's 8N1 transmitter.
- Sits between an asynchronous PMOD pin and fabric logic.
- Synchronises the line, detects the start bit, samples each bit at mid-bit, and presents bytes on a valid/ready interface.
- Flags framing errors and overruns.

Parameters:
- CLK_RATE, 12000000, system clock frequency in Hz.
- BAUD_RATE, 115200, line bit rate.
- CLKS_PER_BIT, CLK_RATE/BAUD_RATE (integer division, 104), clocks per bit period; derived, not overridden.

Ports:
- clk  input  1  system clock.
- reset  input  1  reset, asynchronous, active-high.
- rx  input  1  asynchronous serial line; idle high.
- rx_data  output  8  received byte; stable while rx_valid=1.
- rx_valid  output  1  byte available; held until accepted.
- rx_ready  input  1  consumer accepts byte when rx_valid&&rx_ready.
- rx_busy  output  1  high from start-bit detect until frame end.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: completed byte dropped because the previous byte was not consumed.
- parity_err  output  1  one-cycle pulse on parity mismatch; constant 0 unless UART_RX_PARITY_EN.

Behaviour:
- Reset values:
  - rx_data=0, rx_valid=0, rx_busy=0, frame_err=0, overrun=0, parity_err=0.
  - Synchroniser flops=1.
  - State=IDLE; bit counter and baud counter=0.
- Synchroniser: 2 flops on rx; all logic uses the synchronised value rxs.
- Baud counter: counts 0..CLKS_PER_BIT-1, then wraps to 0. It is cleared on every state entry.
- IDLE:
  - rxs==0 -> START, rx_busy=1.
- START (sampling at count CLKS_PER_BIT/2-1, i.e. 51):
  - rxs==0 -> DATA.
  - rxs==1 -> IDLE, rx_busy=0, no flags. This is glitch rejection.
- DATA:
  - Sample at each counter wrap (mid-bit). Shift into bit 7, right-shifting so the first received bit lands in bit 0.
  - After 8 samples -> STOP.
- STOP (sample at wrap):
  - rxs==1 -> deliver byte, -> IDLE, rx_busy=0.
  - rxs==0 -> frame_err pulse, byte discarded, -> BREAK.
- BREAK:
  - Wait for rxs==1, -> IDLE, rx_busy=0.
  - A held-low line (break) produces exactly one frame_err.
- Deliver byte:
  - Case 1, rx_valid==0, or rx_valid&&rx_ready that same cycle: rx_data<=byte, rx_valid<=1 next cycle.
  - Case 2, otherwise: overrun pulse; rx_data and rx_valid are unchanged and the new byte is dropped.
- Acceptance:
  - rx_valid&&rx_ready with no delivery -> rx_valid<=0 next cycle.
  - rx_data holds its last value after acceptance.
- Latency:
  - Start edge at pin to rx_valid high is nominally 992 clk: 2 sync + 1 detect + 52 + 8*104 + 104 + 1.
  - Bench window is ±4.
- Back-to-back frames: the next start bit may follow the stop bit immediately. IDLE is entered in time to detect it.
- Reset mid-frame: immediate return to reset values; the partial byte is lost.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - 8E1 framing: a PARITY state follows DATA and samples one extra bit.
  - Even parity over the 8 data bits plus the parity bit must be 0.
  - Mismatch -> parity_err pulse at the stop-bit sample. The byte is discarded and the frame_err check still applies.
  - Latency +104 clk.
- Not defined: no PARITY state; parity_err tied 0; 8N1 only.

Decomposition:
- Package uart_pkg:
  - State enum IDLE/START/DATA/PARITY/STOP/BREAK.
  - CLKS_PER_BIT and HALF_BIT computation function.
  - DATA_BITS=8.
- Shared by the transmitter for matching baud math.
- Sub-module uart_rx_sync: 2-flop synchroniser, reset value 1, reused for other async PMOD inputs.

Test Plan:
- Single byte: drive 0x43 at 115200 -> rx_valid rises 992±4 clk after start edge, rx_data=0x43; with rx_ready=1, rx_valid is high exactly 1 cycle.
- Back-to-back: 0x55, 0xAA, 0x00, 0xFF with rx_ready=1 and no idle gap -> four deliveries in order, no error pulses.
- Glitch: rx low for 30 clk, then high -> no rx_valid, no frame_err, rx_busy back to 0 by clk 60.
- Framing/break: send 0x12 with stop bit low, then hold rx low for 3000 clk -> exactly one frame_err pulse, no rx_valid; next valid 0x34 is received correctly.
- Overrun: rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x11, one overrun pulse at the second frame end. Then raise rx_ready on the cycle the third byte 0x33 completes -> rx_data=0x33, no overrun.
- Reset mid-frame: assert reset during bit 4 of 0x5A -> all outputs 0 immediately; next byte 0xC3 is received correctly. With UART_RX_PARITY_EN, a wrong parity on 0x01 -> parity_err pulse, no rx_valid.
